fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue between
//  the Icache/Memory Controller and the Decoder. It keeps fetching while the Decoder
//  is stalled, predicts next PC for JAL/C.J/C.JAL and predicted branches (incl. C.BEQZ/C.BNEZ),
//  and on a ROB flush discards the queue and any in-flight memory response.
// PARAMETERS
//  XLEN        32  data/address width
//  QUEUE_DEPTH 4   queue entries; power of two, >= 2
//  RESET_PC    0   first fetch address after reset
// PORTS
//  clk             in  1     clock; all state updates on posedge
//  rst             in  1     synchronous, active-high reset
//  rdy             in  1     global enable; 0 freezes every register, fq_mem_enable=0
//  flush           in  1     ROB mispredict/redirect
//  rob_correct_pc  in  XLEN  redirect target, valid with flush
//  bp_pred         in  1     taken prediction for fq_pc, sampled on push
//  icache_ready    in  1     Icache hit, valid in S_CHECK
//  icache_inst     in  XLEN  hit data
//  mem_fet_busy    in  1     Memory Controller cannot accept a fetch
//  mem_inst_ready  in  1     memory fetch data valid (one cycle)
//  mem_inst        in  XLEN  memory fetch data
//  dec_ready       in  1     Decoder accepts head entry this cycle
//  fq_icache_enable out 1    registered Icache lookup strobe for fq_pc
//  fq_pc           out XLEN  current fetch address (to Icache, Memory Controller, BP)
//  fq_mem_enable   out 1     combinational: state==S_MEM_REQ && !mem_fet_busy && rdy
//  fq_ready        out 1     queue non-empty
//  fq_inst / fq_inst_addr / fq_jump_pred  out XLEN/XLEN/1  head entry (combinational read)
//  fq_count        out $clog2(QUEUE_DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset: state=S_LOOKUP, fq_pc=RESET_PC, fq_icache_enable=0, head=tail=count=0,
//   discard flag=0, hence fq_ready=0, fq_mem_enable=0; entry storage need not clear.
//  FSM (one outstanding fetch):
//   S_LOOKUP : if count<QUEUE_DEPTH -> fq_icache_enable<=1, go S_CHECK; else hold, enable<=0.
//   S_CHECK  : enable<=0. icache_ready -> push icache_inst, go S_LOOKUP; else go S_MEM_REQ.
//   S_MEM_REQ: fq_mem_enable=1 when !mem_fet_busy; that cycle go S_MEM_WAIT.
//   S_MEM_WAIT: mem_inst_ready -> push mem_inst (unless discard), clear discard, go S_LOOKUP.
//  Icache wins if icache_ready and mem_inst_ready coincide in S_CHECK (mem ignored).
//  Push: entry {inst, fq_pc, bp_pred} at tail; tail+1 mod DEPTH; fq_pc <= next PC:
//   inst[1:0]==11: JAL(1101111) pc+J-imm; BRANCH(1100011)&&bp_pred pc+B-imm; else pc+4.
//   else RVC: [1:0]==01&&[14:13]==01 (C.JAL/C.J) pc+CJ-imm; [1:0]==01&&[15:14]==11
//   (C.BEQZ/C.BNEZ) pc+CB-imm only if bp_pred, else pc+2; other RVC pc+2.
//   Immediates sign-extended to XLEN; sums wrap mod 2^XLEN.
//  Pop: fq_ready && dec_ready -> head+1 mod DEPTH. Push+pop same cycle: count unchanged.
//  Full: count==DEPTH blocks new lookup only; a push never overflows (space checked at issue).
//   Space check uses registered count; a same-cycle pop does not free issue slot.
//  Flush (priority over everything except rst and !rdy): head=tail=count=0, same-cycle
//   push/pop ignored, fq_pc<=rob_correct_pc, fq_icache_enable<=0.
//   In S_MEM_WAIT without mem_inst_ready: set discard, stay S_MEM_WAIT; the next
//   mem_inst_ready is dropped, then S_LOOKUP with the new fq_pc. Otherwise -> S_LOOKUP.
//   Flush in S_MEM_REQ: request not sent this cycle (fq_mem_enable=0 when flush).
//  rst mid-operation overrides flush and pending memory; caller guarantees the Memory
//   Controller is reset together.
//  Latency: Icache hit = push 2 cycles after entering S_LOOKUP; fq_ready next cycle after push.
// TESTING
//  1 Reset, icache hits 0x00000013 at 0,4,8, dec_ready=1 -> fq_inst_addr 0,4,8; push every 2 cycles.
//  2 dec_ready=0, all hits, DEPTH=4 -> fq_count saturates 4, fq_icache_enable stays 0;
//    one pop -> exactly one new lookup.
//  3 inst 0x0080006F (JAL +8) at 0x10 -> next fq_pc 0x18; 0xFE000EE3 (BEQ -4) bp_pred=1 at 0x20
//    -> 0x1C; same with bp_pred=0 -> 0x24; RVC 0x0001 at 0x30 -> 0x32; C.J 0xA001 at 0x40 -> 0x40.
//  4 Miss, mem_fet_busy=1 for 3 cycles -> fq_mem_enable only after busy drops; mem_inst_ready
//    -> entry pushed with fq_pc.
//  5 Flush in S_MEM_WAIT, rob_correct_pc=0x100, mem data 2 cycles later -> data dropped,
//    queue empty, next lookup at 0x100.
//  6 rdy=0 for 5 cycles mid-fetch -> all outputs/counters frozen; resumes identically.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bundle between the fetch queue and its neighbours: ROB redirect, branch
// predictor, Icache, Memory Controller and Decoder.
//
// Handshakes: the Icache answers a lookup in the cycle after
// fq_icache_enable is raised. icache_ready is meaningful only in that cycle.
// A memory fetch is issued in any cycle where fq_mem_enable is high, and
// fq_mem_enable is already qualified with !mem_fet_busy. Exactly one fetch is
// ever outstanding, and the Memory Controller answers it with a single-cycle
// mem_inst_ready pulse. The head entry (fq_inst/fq_inst_addr/fq_jump_pred)
// is valid while fq_ready is high. It is consumed on every clock edge where
// fq_ready && dec_ready.
interface fetch_queue_if #(
  parameter int XLEN        = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic            rdy;
  logic            flush;
  logic [XLEN-1:0] rob_correct_pc;
  logic            bp_pred;
  logic            icache_ready;
  logic [XLEN-1:0] icache_inst;
  logic            mem_fet_busy;
  logic            mem_inst_ready;
  logic [XLEN-1:0] mem_inst;
  logic            dec_ready;

  logic            fq_icache_enable;
  logic [XLEN-1:0] fq_pc;
  logic            fq_mem_enable;
  logic            fq_ready;
  logic [XLEN-1:0] fq_inst;
  logic [XLEN-1:0] fq_inst_addr;
  logic            fq_jump_pred;
  logic [CW-1:0]   fq_count;
  logic [1:0]      fsm_state;

  // Fetch queue side
  modport master (
    input  rdy, flush, rob_correct_pc, bp_pred, icache_ready, icache_inst,
           mem_fet_busy, mem_inst_ready, mem_inst, dec_ready,
    output fq_icache_enable, fq_pc, fq_mem_enable, fq_ready, fq_inst,
           fq_inst_addr, fq_jump_pred, fq_count, fsm_state
  );

  // Environment side (Icache, Memory Controller, Decoder, ROB, BP)
  modport slave (
    output rdy, flush, rob_correct_pc, bp_pred, icache_ready, icache_inst,
           mem_fet_busy, mem_inst_ready, mem_inst, dec_ready,
    input  fq_icache_enable, fq_pc, fq_mem_enable, fq_ready, fq_inst,
           fq_inst_addr, fq_jump_pred, fq_count, fsm_state
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end. It keeps a QUEUE_DEPTH-entry prefetch queue
// and allows one outstanding fetch at a time: first an Icache lookup, then
// a memory fetch if the lookup misses. Each pushed instruction's next PC
// comes from static decode of JAL / C.J / C.JAL and from predicted
// branches. A flush empties the queue and drops any memory response that is
// still in flight. The immediate sign-extension assumes XLEN >= 32.
module fetch_queue #(
  parameter int              XLEN        = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_LOOKUP   = 2'd0,
    S_CHECK    = 2'd1,
    S_MEM_REQ  = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] inst_q [QUEUE_DEPTH];
  logic [XLEN-1:0] addr_q [QUEUE_DEPTH];
  logic            pred_q [QUEUE_DEPTH];

  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            discard;
  logic [XLEN-1:0] pc;
  logic            icache_en;

  logic            has_space;
  logic            push_icache, push_mem, push, pop;
  logic [XLEN-1:0] push_inst, next_pc;

  logic [20:0]     j_imm;
  logic [12:0]     b_imm;
  logic [11:0]     cj_imm;
  logic [8:0]      cb_imm;

  // The issue decision uses the registered occupancy, so a pop in the same
  // cycle does not open a slot until the next cycle.
  assign has_space = (count < DEPTH_C);

  // Choose the push source and decide whether a push and/or pop occur
  always_comb begin
    push_icache = (state == S_CHECK) && bus.icache_ready;
    push_mem    = (state == S_MEM_WAIT) && bus.mem_inst_ready && !discard;
    push        = (push_icache || push_mem) && !bus.flush;
    push_inst   = push_icache ? bus.icache_inst : bus.mem_inst;
    pop         = (count != '0) && bus.dec_ready && !bus.flush;
  end

  // Compute the next fetch address from the instruction being pushed
  always_comb begin
    j_imm   = {push_inst[31], push_inst[19:12], push_inst[20], push_inst[30:21], 1'b0};
    b_imm   = {push_inst[31], push_inst[7], push_inst[30:25], push_inst[11:8], 1'b0};
    cj_imm  = {push_inst[12], push_inst[8], push_inst[10:9], push_inst[6], push_inst[7],
               push_inst[2], push_inst[11], push_inst[5:3], 1'b0};
    cb_imm  = {push_inst[12], push_inst[6:5], push_inst[2], push_inst[11:10],
               push_inst[4:3], 1'b0};
    next_pc = pc + XLEN'(4);
    if (push_inst[1:0] == 2'b11) begin
      if (push_inst[6:0] == 7'b1101111) begin
        next_pc = pc + {{(XLEN-21){j_imm[20]}}, j_imm};
      end else if (push_inst[6:0] == 7'b1100011 && bus.bp_pred) begin
        next_pc = pc + {{(XLEN-13){b_imm[12]}}, b_imm};
      end
    end else begin
      next_pc = pc + XLEN'(2);
      if (push_inst[1:0] == 2'b01 && push_inst[14:13] == 2'b01) begin
        next_pc = pc + {{(XLEN-12){cj_imm[11]}}, cj_imm};
      end else if (push_inst[1:0] == 2'b01 && push_inst[15:14] == 2'b11 && bus.bp_pred) begin
        next_pc = pc + {{(XLEN-9){cb_imm[8]}}, cb_imm};
      end
    end
  end

  // FSM state register, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOOKUP;
    end else if (bus.rdy) begin
      state <= state_next;
    end
  end

  // FSM next-state logic. A flush during an unanswered memory fetch waits
  // for the stale response, which is then discarded.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      if (state == S_MEM_WAIT && !bus.mem_inst_ready) begin
        state_next = S_MEM_WAIT;
      end else begin
        state_next = S_LOOKUP;
      end
    end else begin
      case (state)
        S_LOOKUP:   if (has_space) state_next = S_CHECK;
        S_CHECK:    state_next = bus.icache_ready ? S_LOOKUP : S_MEM_REQ;
        S_MEM_REQ:  if (!bus.mem_fet_busy) state_next = S_MEM_WAIT;
        S_MEM_WAIT: if (bus.mem_inst_ready) state_next = S_LOOKUP;
        default:    state_next = S_LOOKUP;
      endcase
    end
  end

  // FSM outputs: memory request strobe and debug state
  always_comb begin
    bus.fq_mem_enable = (state == S_MEM_REQ) && !bus.mem_fet_busy && bus.rdy && !bus.flush;
    bus.fsm_state     = state;
  end

  // Queue pointers, occupancy, fetch PC, lookup strobe and discard flag
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pc        <= RESET_PC;
      icache_en <= 1'b0;
      discard   <= 1'b0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        pc        <= bus.rob_correct_pc;
        icache_en <= 1'b0;
        discard   <= (state == S_MEM_WAIT) && !bus.mem_inst_ready;
      end else begin
        icache_en <= (state == S_LOOKUP) && has_space;
        if (push) begin
          tail <= tail + AW'(1);
          pc   <= next_pc;
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
        if (state == S_MEM_WAIT && bus.mem_inst_ready) begin
          discard <= 1'b0;
        end
      end
    end
  end

  // Entry storage; written only on push, so it needs no reset
  always_ff @(posedge clk) begin
    if (bus.rdy && push) begin
      inst_q[tail] <= push_inst;
      addr_q[tail] <= pc;
      pred_q[tail] <= bus.bp_pred;
    end
  end

  assign bus.fq_icache_enable = icache_en;
  assign bus.fq_pc            = pc;
  assign bus.fq_ready         = (count != '0);
  assign bus.fq_count         = count;
  assign bus.fq_inst          = inst_q[head];
  assign bus.fq_inst_addr     = addr_q[head];
  assign bus.fq_jump_pred     = pred_q[head];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed sequences, a next-PC vector table and a
// randomized run checked against a transaction-level queue model.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .QUEUE_DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];      // {pred, addr, inst}
  logic [31:0] pop_log[$];
  int          push_log[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;

  logic [31:0] model_pc;
  logic        req_wait, mem_pending, mem_drop;
  int          mem_lat;

  int          k_hit, k_dec, k_busy, k_flush, k_stall;
  logic        k_fixed;
  logic [31:0] fixed_inst;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] exp_next;
  } pc_vec_t;

  pc_vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC computed with plain integer offsets from the encoding tables
  function automatic logic [31:0] ref_next(input logic [31:0] i, input logic [31:0] pc,
                                           input logic pred);
    int off;
    off = 4;
    if (i[1:0] == 2'b11) begin
      if (i[6:0] == 7'b1101111) begin
        off = (int'(i[30:21]) << 1) + (int'(i[20]) << 11) + (int'(i[19:12]) << 12);
        if (i[31]) off -= (1 << 20);
      end else if (i[6:0] == 7'b1100011 && pred) begin
        off = (int'(i[11:8]) << 1) + (int'(i[30:25]) << 5) + (int'(i[7]) << 11);
        if (i[31]) off -= (1 << 12);
      end
    end else begin
      off = 2;
      if (i[1:0] == 2'b01 && i[14:13] == 2'b01) begin
        off = (int'(i[5:3]) << 1) + (int'(i[11]) << 4) + (int'(i[2]) << 5) +
              (int'(i[7]) << 6) + (int'(i[6]) << 7) + (int'(i[10:9]) << 8) +
              (int'(i[8]) << 10);
        if (i[12]) off -= (1 << 11);
      end else if (i[1:0] == 2'b01 && i[15:14] == 2'b11 && pred) begin
        off = (int'(i[4:3]) << 1) + (int'(i[11:10]) << 3) + (int'(i[2]) << 5) +
              (int'(i[6:5]) << 6);
        if (i[12]) off -= (1 << 8);
      end
    end
    return pc + 32'(off);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0013;
      1:       return {r[31:7], 7'b1101111};
      2:       return {r[31:7], 7'b1100011};
      3:       return {r[31:2], 2'b01};
      4:       return {r[31:2], r[1], 1'b0};
      default: return {r[31:2], 2'b11};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.rdy            = 1'b1;
    bus.flush          = 1'b0;
    bus.rob_correct_pc = '0;
    bus.bp_pred        = 1'b0;
    bus.icache_ready   = 1'b0;
    bus.icache_inst    = '0;
    bus.mem_fet_busy   = 1'b0;
    bus.mem_inst_ready = 1'b0;
    bus.mem_inst       = '0;
    bus.dec_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    model_pc    = 32'h0;
    req_wait    = 1'b0;
    mem_pending = 1'b0;
    mem_drop    = 1'b0;
    mem_lat     = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until a lookup is in flight (Icache answer cycle)
  task automatic wait_lookup(input string name);
    for (int n = 0; n < 8; n++) begin
      if (bus.fq_icache_enable) break;
      tick();
    end
    check(name, bus.fq_icache_enable, 1'b1);
  endtask

  task automatic model_push(input logic [31:0] inst);
    check("push_pc", bus.fq_pc, model_pc);
    exp_q.push_back({bus.bp_pred, model_pc, inst});
    push_log.push_back(cyc);
    model_pc = ref_next(inst, model_pc, bus.bp_pred);
  endtask

  // One clock of environment behaviour plus model bookkeeping.
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle();
    logic        in_check, exp_men, pop_now, resp;
    logic [31:0] ii, mi;
    check("count", 32'(bus.fq_count), 32'(exp_q.size()));
    check("ready", bus.fq_ready, exp_q.size() != 0);
    in_check           = bus.fq_icache_enable;
    bus.rdy            = $urandom_range(0, 99) >= k_stall;
    bus.flush          = $urandom_range(0, 99) < k_flush;
    bus.rob_correct_pc = $urandom & 32'hFFFF_FFFE;
    bus.bp_pred        = 1'($urandom_range(0, 1));
    bus.dec_ready      = $urandom_range(0, 99) < k_dec;
    bus.mem_fet_busy   = $urandom_range(0, 99) < k_busy;
    ii                 = k_fixed ? fixed_inst : rand_inst();
    bus.icache_inst    = ii;
    bus.icache_ready   = in_check ? ($urandom_range(0, 99) < k_hit) : ($urandom_range(0, 3) == 0);
    resp               = mem_pending && mem_lat == 0 && bus.rdy;
    mi                 = rand_inst();
    bus.mem_inst       = mi;
    bus.mem_inst_ready = resp;
    #1;
    exp_men = req_wait && !bus.mem_fet_busy && bus.rdy && !bus.flush;
    check("mem_enable", bus.fq_mem_enable, exp_men);
    if (bus.rdy) begin
      pop_now = exp_q.size() != 0 && bus.dec_ready && !bus.flush;
      if (pop_now) begin
        check("head_inst", bus.fq_inst, exp_q[0][31:0]);
        check("head_addr", bus.fq_inst_addr, exp_q[0][63:32]);
        check("head_pred", bus.fq_jump_pred, exp_q[0][64]);
        pop_log.push_back(exp_q[0][63:32]);
        void'(exp_q.pop_front());
      end
      if (exp_men) begin
        mem_pending = 1'b1;
        mem_lat     = $urandom_range(0, 3);
        req_wait    = 1'b0;
      end else if (mem_pending && !resp && mem_lat > 0) begin
        mem_lat--;
      end
      if (bus.flush) begin
        exp_q.delete();
        model_pc = bus.rob_correct_pc;
        req_wait = 1'b0;
        if (resp) begin
          mem_pending = 1'b0;
          mem_drop    = 1'b0;
        end else if (mem_pending) begin
          mem_drop = 1'b1;
        end
      end else begin
        if (in_check && bus.icache_ready) model_push(ii);
        else if (in_check) req_wait = 1'b1;
        if (resp) begin
          mem_pending = 1'b0;
          if (mem_drop) mem_drop = 1'b0;
          else model_push(mi);
        end
      end
    end
    tick();
    cyc++;
  endtask

  task automatic set_knobs(input int hit, input int dec, input int busy, input int fl,
                           input int st);
    k_hit = hit; k_dec = dec; k_busy = busy; k_flush = fl; k_stall = st;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n_en;
    vecs[0]  = '{32'h0080_006F, 32'h0000_0010, 1'b0, 32'h0000_0018};
    vecs[1]  = '{32'hFE00_0EE3, 32'h0000_0020, 1'b1, 32'h0000_001C};
    vecs[2]  = '{32'hFE00_0EE3, 32'h0000_0020, 1'b0, 32'h0000_0024};
    vecs[3]  = '{32'h0000_0001, 32'h0000_0030, 1'b0, 32'h0000_0032};
    vecs[4]  = '{32'h0000_A001, 32'h0000_0040, 1'b0, 32'h0000_0040};
    vecs[5]  = '{32'hFFDF_F06F, 32'h0000_0100, 1'b0, 32'h0000_00FC};
    vecs[6]  = '{32'h0000_C401, 32'h0000_0200, 1'b1, 32'h0000_0208};
    vecs[7]  = '{32'h0000_C401, 32'h0000_0200, 1'b0, 32'h0000_0202};
    vecs[8]  = '{32'h0000_BFFD, 32'h0000_0300, 1'b1, 32'h0000_02FE};
    vecs[9]  = '{32'h0000_0013, 32'h0000_0400, 1'b1, 32'h0000_0404};
    vecs[10] = '{32'h0080_006F, 32'hFFFF_FFFC, 1'b0, 32'h0000_0004};
    vecs[11] = '{32'h0000_4501, 32'h0000_0500, 1'b1, 32'h0000_0502};
    vecs[12] = '{32'h0000_E401, 32'h0000_0600, 1'b1, 32'h0000_0608};

    // Reset values, then back-to-back Icache hits with the decoder ready
    k_fixed = 1'b1;
    fixed_inst = 32'h0000_0013;
    do_reset();
    check("rst_ready", bus.fq_ready, 1'b0);
    check("rst_count", 32'(bus.fq_count), 32'd0);
    check("rst_icache_en", bus.fq_icache_enable, 1'b0);
    check("rst_mem_en", bus.fq_mem_enable, 1'b0);
    check("rst_pc", bus.fq_pc, 32'h0);
    set_knobs(100, 100, 0, 0, 0);
    pop_log.delete();
    push_log.delete();
    repeat (8) cycle();
    check("t1_pops", pop_log.size() >= 3, 1'b1);
    if (pop_log.size() >= 3) begin
      check("t1_addr0", pop_log[0], 32'h0);
      check("t1_addr1", pop_log[1], 32'h4);
      check("t1_addr2", pop_log[2], 32'h8);
    end
    if (push_log.size() >= 3) begin
      check("t1_gap0", 32'(push_log[1] - push_log[0]), 32'd2);
      check("t1_gap1", 32'(push_log[2] - push_log[1]), 32'd2);
    end

    // Decoder stalled: queue fills to DEPTH, then one pop frees one lookup
    set_knobs(100, 0, 0, 0, 0);
    repeat (14) cycle();
    check("t2_full", 32'(bus.fq_count), 32'(DEPTH));
    for (int n = 0; n < 4; n++) begin
      cycle();
      check("t2_no_lookup", bus.fq_icache_enable, 1'b0);
    end
    k_dec = 100;
    cycle();
    k_dec = 0;
    n_en = 0;
    for (int n = 0; n < 6; n++) begin
      cycle();
      n_en += int'(bus.fq_icache_enable);
    end
    check("t2_one_lookup", 32'(n_en), 32'd1);
    check("t2_refull", 32'(bus.fq_count), 32'(DEPTH));

    // Next-PC table: redirect to the vector PC, answer one hit, check
    idle_inputs();
    foreach (vecs[v]) begin
      bus.flush = 1'b1;
      bus.rob_correct_pc = vecs[v].pc;
      tick();
      bus.flush = 1'b0;
      wait_lookup("tbl_lookup");
      bus.icache_ready = 1'b1;
      bus.icache_inst  = vecs[v].inst;
      bus.bp_pred      = vecs[v].pred;
      tick();
      bus.icache_ready = 1'b0;
      check($sformatf("tbl%0d_next_pc", v), bus.fq_pc, vecs[v].exp_next);
      check($sformatf("tbl%0d_addr", v), bus.fq_inst_addr, vecs[v].pc);
      check($sformatf("tbl%0d_inst", v), bus.fq_inst, vecs[v].inst);
      check($sformatf("tbl%0d_pred", v), bus.fq_jump_pred, vecs[v].pred);
    end

    // Miss with a busy memory controller, then the data returns
    do_reset();
    wait_lookup("t4_lookup");
    bus.icache_ready = 1'b0;
    bus.mem_fet_busy = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      check("t4_busy_no_req", bus.fq_mem_enable, 1'b0);
      tick();
    end
    bus.mem_fet_busy = 1'b0;
    bus.rdy = 1'b0;
    #1 check("t4_rdy0_no_req", bus.fq_mem_enable, 1'b0);
    bus.rdy = 1'b1;
    bus.flush = 1'b1;
    #1 check("t4_flush_no_req", bus.fq_mem_enable, 1'b0);
    bus.flush = 1'b0;
    #1 check("t4_req", bus.fq_mem_enable, 1'b1);
    tick();
    check("t4_req_once", bus.fq_mem_enable, 1'b0);
    tick();
    bus.mem_inst_ready = 1'b1;
    bus.mem_inst = 32'h0000_0013;
    bus.bp_pred = 1'b1;
    tick();
    bus.mem_inst_ready = 1'b0;
    check("t4_count", 32'(bus.fq_count), 32'd1);
    check("t4_inst", bus.fq_inst, 32'h0000_0013);
    check("t4_addr", bus.fq_inst_addr, 32'h0);
    check("t4_pred", bus.fq_jump_pred, 1'b1);
    check("t4_pc", bus.fq_pc, 32'h4);

    // Flush while a memory fetch is outstanding: late data is dropped
    do_reset();
    wait_lookup("t5_lookup");
    bus.icache_ready = 1'b0;
    tick();
    check("t5_req", bus.fq_mem_enable, 1'b1);
    tick();
    bus.flush = 1'b1;
    bus.rob_correct_pc = 32'h100;
    tick();
    bus.flush = 1'b0;
    check("t5_count", 32'(bus.fq_count), 32'd0);
    check("t5_pc", bus.fq_pc, 32'h100);
    check("t5_no_lookup0", bus.fq_icache_enable, 1'b0);
    tick();
    check("t5_no_lookup1", bus.fq_icache_enable, 1'b0);
    bus.mem_inst_ready = 1'b1;
    bus.mem_inst = 32'h0080_006F;
    tick();
    bus.mem_inst_ready = 1'b0;
    check("t5_dropped", 32'(bus.fq_count), 32'd0);
    check("t5_not_ready", bus.fq_ready, 1'b0);
    wait_lookup("t5_relookup");
    check("t5_lookup_pc", bus.fq_pc, 32'h100);
    bus.icache_ready = 1'b1;
    bus.icache_inst = 32'h0000_0013;
    tick();
    bus.icache_ready = 1'b0;
    check("t5_entry_addr", bus.fq_inst_addr, 32'h100);
    check("t5_entry_count", 32'(bus.fq_count), 32'd1);

    // rdy low for 5 cycles during a lookup freezes everything
    do_reset();
    wait_lookup("t6_lookup0");
    bus.icache_ready = 1'b1;
    bus.icache_inst = 32'h0000_0013;
    tick();
    bus.icache_ready = 1'b0;
    wait_lookup("t6_lookup1");
    bus.rdy = 1'b0;
    bus.icache_ready = 1'b1;
    bus.icache_inst = 32'h0080_006F;
    bus.flush = 1'b1;
    bus.rob_correct_pc = 32'h700;
    bus.dec_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t6_frz_count", 32'(bus.fq_count), 32'd1);
      check("t6_frz_pc", bus.fq_pc, 32'h4);
      check("t6_frz_en", bus.fq_icache_enable, 1'b1);
      check("t6_frz_addr", bus.fq_inst_addr, 32'h0);
      check("t6_frz_men", bus.fq_mem_enable, 1'b0);
    end
    bus.rdy = 1'b1;
    bus.flush = 1'b0;
    bus.dec_ready = 1'b0;
    bus.icache_inst = 32'h0000_0013;
    tick();
    bus.icache_ready = 1'b0;
    check("t6_resume_count", 32'(bus.fq_count), 32'd2);
    check("t6_resume_pc", bus.fq_pc, 32'h8);
    check("t6_resume_en", bus.fq_icache_enable, 1'b0);

    // Randomized traffic against the queue model
    do_reset();
    k_fixed = 1'b0;
    set_knobs(60, 50, 30, 3, 5);
    repeat (3000) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
